// File: rtl/roce_stack_mm2s_engine_if.sv
// roce_stack_mm2s_engine_if: command, AXI4 read, AXI-Stream and status bus of the MM2S engine.
// ROCE_MM2S_PERF_CNT_EN adds the perf counter outputs.
interface roce_stack_mm2s_engine_if #(
  parameter int AXI4_DATA_WIDTH = 512,
  parameter int LEN_WIDTH = 28
);
  localparam int BYTES = AXI4_DATA_WIDTH / 8;
  logic s_cmd_valid_i;
  logic s_cmd_ready_o;
  logic [63:0] s_cmd_addr_i;
  logic [LEN_WIDTH-1:0] s_cmd_len_i;
  logic s_cmd_ctl_i;
  logic m_axi_arid_o;
  logic [63:0] m_axi_araddr_o;
  logic [7:0] m_axi_arlen_o;
  logic [2:0] m_axi_arsize_o;
  logic [1:0] m_axi_arburst_o;
  logic [3:0] m_axi_arcache_o;
  logic [2:0] m_axi_arprot_o;
  logic m_axi_arvalid_o;
  logic m_axi_arready_i;
  logic [AXI4_DATA_WIDTH-1:0] m_axi_rdata_i;
  logic [1:0] m_axi_rresp_i;
  logic m_axi_rlast_i;
  logic m_axi_rvalid_i;
  logic m_axi_rready_o;
  logic [AXI4_DATA_WIDTH-1:0] m_axis_tdata_o;
  logic [BYTES-1:0] m_axis_tkeep_o;
  logic m_axis_tlast_o;
  logic m_axis_tvalid_o;
  logic m_axis_tready_i;
  logic m_sts_valid_o;
  logic m_sts_ready_i;
  logic m_sts_err_o;
  logic m_sts_ctl_o;
`ifdef ROCE_MM2S_PERF_CNT_EN
  logic [63:0] perf_bytes_o;
  logic [31:0] perf_stall_cycles_o;
`endif
  modport master (
    input s_cmd_valid_i, s_cmd_addr_i, s_cmd_len_i, s_cmd_ctl_i,
    input m_axi_arready_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rlast_i, m_axi_rvalid_i,
    input m_axis_tready_i, m_sts_ready_i,
`ifdef ROCE_MM2S_PERF_CNT_EN
    output perf_bytes_o, perf_stall_cycles_o,
`endif
    output s_cmd_ready_o, m_axi_arid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o,
    output m_axi_arburst_o, m_axi_arcache_o, m_axi_arprot_o, m_axi_arvalid_o, m_axi_rready_o,
    output m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o, m_axis_tvalid_o,
    output m_sts_valid_o, m_sts_err_o, m_sts_ctl_o
  );
  modport slave (
    output s_cmd_valid_i, s_cmd_addr_i, s_cmd_len_i, s_cmd_ctl_i,
    output m_axi_arready_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rlast_i, m_axi_rvalid_i,
    output m_axis_tready_i, m_sts_ready_i,
`ifdef ROCE_MM2S_PERF_CNT_EN
    input perf_bytes_o, perf_stall_cycles_o,
`endif
    input s_cmd_ready_o, m_axi_arid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o,
    input m_axi_arburst_o, m_axi_arcache_o, m_axi_arprot_o, m_axi_arvalid_o, m_axi_rready_o,
    input m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o, m_axis_tvalid_o,
    input m_sts_valid_o, m_sts_err_o, m_sts_ctl_o
  );
endinterface

// File: rtl/roce_stack_mm2s_engine.sv
// roce_stack_mm2s_engine: splits a read command into 4 KB-safe AXI4 INCR bursts and streams the data out.
// ROCE_MM2S_PERF_CNT_EN adds byte and stall counters.
module roce_stack_mm2s_engine #(
  parameter int AXI4_DATA_WIDTH = 512,
  parameter int LEN_WIDTH = 28,
  parameter int MAX_BURST_BEATS = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic AXI_ID = 1'b0
) (
  input logic axis_aclk_i,
  input logic rst_i,
  roce_stack_mm2s_engine_if.master bus
);
  localparam int BYTES = AXI4_DATA_WIDTH / 8;
  localparam int BW = $clog2(BYTES);
  localparam int NW = LEN_WIDTH - BW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, STATUS} state_t;
  state_t r_state, w_next;
  logic [63:0] r_addr;
  logic [NW-1:0] r_ar_rem, r_dat_rem, w_total, w_dat_nxt;
  logic [BW:0] r_last_bytes, w_last_bytes;
  logic r_ctl, r_err;
  logic [OW-1:0] r_outst, w_outst_nxt;
  logic [12:0] w_pg, w_cap;
  logic [8:0] w_beats;
  logic w_ok, w_arvalid, w_ar_hs, w_r_hs, w_tlast, w_cmd_hs, w_sts_hs;
  assign w_total = NW'(({1'b0, bus.s_cmd_len_i} + (LEN_WIDTH+1)'(BYTES - 1)) >> BW);
  assign w_last_bytes = (bus.s_cmd_len_i[BW-1:0] == '0) ? (BW+1)'(BYTES) : {1'b0, bus.s_cmd_len_i[BW-1:0]};
  // Beats left before the next 4 KB page, capped by burst size and remaining command beats
  assign w_pg = (13'd4096 - {1'b0, r_addr[11:0]}) >> BW;
  assign w_cap = (w_pg > 13'(MAX_BURST_BEATS)) ? 13'(MAX_BURST_BEATS) : w_pg;
  assign w_beats = (32'(w_cap) > 32'(r_ar_rem)) ? 9'(r_ar_rem) : w_cap[8:0];
  assign w_ok = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_arvalid = (r_state == ISSUE) && (r_outst < OW'(MAX_OUTSTANDING));
  assign w_ar_hs = w_arvalid && bus.m_axi_arready_i;
  assign w_r_hs = w_ok && bus.m_axi_rvalid_i && bus.m_axis_tready_i;
  assign w_tlast = r_dat_rem == NW'(1);
  assign w_cmd_hs = (r_state == IDLE) && !rst_i && bus.s_cmd_valid_i;
  assign w_sts_hs = (r_state == STATUS) && bus.m_sts_ready_i;
  assign w_outst_nxt = r_outst + OW'(w_ar_hs) - OW'(w_r_hs && bus.m_axi_rlast_i);
  assign w_dat_nxt = r_dat_rem - NW'(w_r_hs);
  assign bus.m_axi_arid_o = AXI_ID;
  assign bus.m_axi_araddr_o = r_addr;
  assign bus.m_axi_arlen_o = 8'(w_beats - 9'd1);
  assign bus.m_axi_arsize_o = 3'(BW);
  assign bus.m_axi_arburst_o = 2'b01;
  assign bus.m_axi_arcache_o = 4'b0011;
  assign bus.m_axi_arprot_o = 3'b000;
  assign bus.m_axis_tdata_o = bus.m_axi_rdata_i;
  assign bus.m_axis_tlast_o = w_tlast;
  assign bus.m_axis_tkeep_o = w_tlast ? ~({BYTES{1'b1}} << r_last_bytes) : {BYTES{1'b1}};
  assign bus.m_sts_err_o = r_err;
  assign bus.m_sts_ctl_o = r_ctl;
  always_ff @(posedge axis_aclk_i)
    r_state <= rst_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    bus.s_cmd_ready_o = (r_state == IDLE) && !rst_i;
    bus.m_axi_arvalid_o = w_arvalid;
    bus.m_axi_rready_o = w_ok && bus.m_axis_tready_i;
    bus.m_axis_tvalid_o = w_ok && bus.m_axi_rvalid_i;
    bus.m_sts_valid_o = r_state == STATUS;
    case (r_state)
      IDLE: w_next = !w_cmd_hs ? IDLE : (bus.s_cmd_len_i == '0) ? STATUS : ISSUE;
      ISSUE: w_next = (w_ar_hs && r_ar_rem == NW'(w_beats)) ? DRAIN : ISSUE;
      DRAIN: w_next = (w_dat_nxt == '0 && w_outst_nxt == '0) ? STATUS : DRAIN;
      default: w_next = w_sts_hs ? IDLE : STATUS;
    endcase
  end
  always_ff @(posedge axis_aclk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_ar_rem <= '0;
      r_dat_rem <= '0;
      r_last_bytes <= '0;
      r_ctl <= 1'b0;
      r_err <= 1'b0;
      r_outst <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (w_cmd_hs) begin
        r_addr <= bus.s_cmd_addr_i & ~64'(BYTES - 1);
        r_ar_rem <= w_total;
        r_dat_rem <= w_total;
        r_last_bytes <= w_last_bytes;
        r_ctl <= bus.s_cmd_ctl_i;
        r_err <= 1'b0;
      end else begin
        if (w_ar_hs) begin
          r_addr <= r_addr + (64'(w_beats) << BW);
          r_ar_rem <= r_ar_rem - NW'(w_beats);
        end
        r_dat_rem <= w_dat_nxt;
        if (w_r_hs && bus.m_axi_rresp_i != 2'b00) r_err <= 1'b1;
      end
    end
  end
`ifdef ROCE_MM2S_PERF_CNT_EN
  logic [63:0] r_perf_bytes;
  logic [31:0] r_perf_stall;
  always_ff @(posedge axis_aclk_i) begin
    if (rst_i) begin
      r_perf_bytes <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_cmd_hs) r_perf_bytes <= r_perf_bytes + 64'(bus.s_cmd_len_i);
      if (w_ok && bus.m_axi_rvalid_i && !bus.m_axis_tready_i && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end
  assign bus.perf_bytes_o = r_perf_bytes;
  assign bus.perf_stall_cycles_o = r_perf_stall;
`endif
endmodule

// File: tb/tb_roce_stack_mm2s_engine.sv
// tb_roce_stack_mm2s_engine: scoreboard bench with an AXI4 read slave model driving the MM2S engine.
module tb_roce_stack_mm2s_engine;
  localparam int BYTES = 64;
  localparam int MBB = 16;
  typedef struct packed {logic [63:0] a; logic [7:0] l;} burst_t;
  typedef struct packed {logic [511:0] d; logic [63:0] k; logic l;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  burst_t exp_ar[$];
  beat_t exp_beat[$];
  logic [1:0] exp_sts[$];
  burst_t sl_q[$];
  int sl_beat = 0;
  int g_rb = 0;
  int err_at = -1;
  int ar_cnt = 0;
  bit r_en = 1'b1;
  bit tr_rand = 1'b0;
  always #5 clk = ~clk;
  roce_stack_mm2s_engine_if #(.AXI4_DATA_WIDTH(512), .LEN_WIDTH(28)) bus ();
  roce_stack_mm2s_engine #(.MAX_BURST_BEATS(MBB)) dut (.axis_aclk_i(clk), .rst_i(rst), .bus(bus.master));
  function automatic logic [511:0] pat(input logic [63:0] a);
    return {4{a, ~a ^ 64'h0123_4567_89AB_CDEF}};
  endfunction
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [63:0] a, input int len, input logic ctl, input int eb);
    logic [63:0] p;
    int n, rem, lb;
    bit got;
    beat_t bt;
    p = {a[63:6], 6'b0};
    n = (len + BYTES - 1) / BYTES;
    rem = n;
    lb = (len % BYTES == 0) ? BYTES : len % BYTES;
    while (rem > 0) begin
      int pg, b;
      pg = (4096 - int'(p[11:0])) / BYTES;
      b = rem;
      if (b > MBB) b = MBB;
      if (b > pg) b = pg;
      exp_ar.push_back('{a: p, l: 8'(b - 1)});
      p += 64'(b * BYTES);
      rem -= b;
    end
    for (int i = 0; i < n; i++) begin
      bt.d = pat({a[63:6], 6'b0} + 64'(i * BYTES));
      bt.l = (i == n - 1);
      bt.k = (bt.l && lb != BYTES) ? ((64'd1 << lb) - 64'd1) : '1;
      exp_beat.push_back(bt);
    end
    exp_sts.push_back({eb >= 0, ctl});
    err_at = (eb >= 0) ? g_rb + eb : -1;
    bus.s_cmd_addr_i = a;
    bus.s_cmd_len_i = 28'(len);
    bus.s_cmd_ctl_i = ctl;
    bus.s_cmd_valid_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.s_cmd_ready_o;
      @(posedge clk);
      #1;
    end
    bus.s_cmd_valid_i = 1'b0;
    chk("cmd_accept", got, 1);
  endtask
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((exp_ar.size() + exp_beat.size() + exp_sts.size()) != 0 && k < 5000) begin
      cyc(1);
      k++;
    end
    chk({tag, "_done"}, k < 5000, 1);
  endtask
  // AXI4 read slave and output monitor: sample at negedge, update driven inputs just after posedge
  initial begin
    bit ar_hs, r_hs, t_hs, s_hs;
    burst_t cap, e;
    beat_t eb;
    logic [1:0] es;
    bus.m_axi_rvalid_i = 1'b0;
    bus.m_axi_rdata_i = '0;
    bus.m_axi_rresp_i = 2'b00;
    bus.m_axi_rlast_i = 1'b0;
    bus.m_axis_tready_i = 1'b1;
    forever begin
      @(negedge clk);
      ar_hs = 1'b0;
      r_hs = 1'b0;
      if (!rst) begin
        ar_hs = bus.m_axi_arvalid_o && bus.m_axi_arready_i;
        r_hs = bus.m_axi_rvalid_i && bus.m_axi_rready_o;
        t_hs = bus.m_axis_tvalid_o && bus.m_axis_tready_i;
        s_hs = bus.m_sts_valid_o && bus.m_sts_ready_i;
        if (ar_hs) begin
          ar_cnt++;
          cap = '{a: bus.m_axi_araddr_o, l: bus.m_axi_arlen_o};
          chk("ar_expected", exp_ar.size() > 0, 1);
          if (exp_ar.size() > 0) begin
            e = exp_ar.pop_front();
            chk("araddr", cap.a, e.a);
            chk("arlen", cap.l, e.l);
          end
          chk("ar_fixed", {bus.m_axi_arid_o, bus.m_axi_arsize_o, bus.m_axi_arburst_o, bus.m_axi_arcache_o, bus.m_axi_arprot_o},
              {1'b0, 3'd6, 2'b01, 4'b0011, 3'b000});
        end
        if (t_hs) begin
          chk("beat_expected", exp_beat.size() > 0, 1);
          if (exp_beat.size() > 0) begin
            eb = exp_beat.pop_front();
            chk("tdata", bus.m_axis_tdata_o, eb.d);
            chk("tkeep", bus.m_axis_tkeep_o, eb.k);
            chk("tlast", bus.m_axis_tlast_o, eb.l);
          end
        end
        if (s_hs) begin
          chk("sts_expected", exp_sts.size() > 0, 1);
          if (exp_sts.size() > 0) begin
            es = exp_sts.pop_front();
            chk("sts_err", bus.m_sts_err_o, es[1]);
            chk("sts_ctl", bus.m_sts_ctl_o, es[0]);
          end
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        sl_q.delete();
        sl_beat = 0;
      end else begin
        if (r_hs && sl_q.size() > 0) begin
          g_rb++;
          if (sl_beat == int'(sl_q[0].l)) begin
            void'(sl_q.pop_front());
            sl_beat = 0;
          end else sl_beat++;
        end
        if (ar_hs) sl_q.push_back(cap);
      end
      bus.m_axi_rvalid_i = r_en && sl_q.size() > 0;
      if (sl_q.size() > 0) begin
        bus.m_axi_rdata_i = pat(sl_q[0].a + 64'(sl_beat * BYTES));
        bus.m_axi_rlast_i = sl_beat == int'(sl_q[0].l);
        bus.m_axi_rresp_i = (g_rb == err_at) ? 2'b10 : 2'b00;
      end else begin
        bus.m_axi_rdata_i = '0;
        bus.m_axi_rlast_i = 1'b0;
        bus.m_axi_rresp_i = 2'b00;
      end
      bus.m_axis_tready_i = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    bus.s_cmd_valid_i = 1'b0;
    bus.s_cmd_addr_i = '0;
    bus.s_cmd_len_i = '0;
    bus.s_cmd_ctl_i = 1'b0;
    bus.m_axi_arready_i = 1'b1;
    bus.m_sts_ready_i = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("rst_cmd_ready", bus.s_cmd_ready_o, 0);
    chk("rst_valids", {bus.m_axi_arvalid_o, bus.m_axis_tvalid_o, bus.m_sts_valid_o}, 3'b000);
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", bus.s_cmd_ready_o, 1);
    cyc(1);
    send(64'h1000, 256, 1'b1, -1);
    wait_done("single_burst");
    send(64'h0FC0, 128, 1'b0, -1);
    wait_done("page_split");
    r_en = 1'b0;
    c0 = ar_cnt;
    send(64'h0, 8192, 1'b1, -1);
    cyc(20);
    @(negedge clk);
    chk("outstanding_cap_ars", ar_cnt - c0, 4);
    chk("outstanding_cap_arvalid", bus.m_axi_arvalid_o, 0);
    cyc(1);
    r_en = 1'b1;
    wait_done("long_read");
    chk("long_read_ars", ar_cnt - c0, 8);
    send(64'h2000, 100, 1'b0, -1);
    wait_done("partial_last");
    tr_rand = 1'b1;
    send(64'h3000, 256, 1'b1, 1);
    wait_done("rresp_err");
    send(64'h3000, 256, 1'b0, -1);
    wait_done("err_cleared");
    tr_rand = 1'b0;
    send(64'h4010, 64, 1'b1, -1);
    wait_done("unaligned_addr");
    bus.m_sts_ready_i = 1'b0;
    c0 = ar_cnt;
    send(64'h5000, 0, 1'b1, -1);
    @(negedge clk);
    chk("len0_sts_valid", bus.m_sts_valid_o, 1);
    chk("len0_cmd_ready", bus.s_cmd_ready_o, 0);
    cyc(3);
    @(negedge clk);
    chk("len0_sts_hold", bus.m_sts_valid_o, 1);
    cyc(1);
    bus.m_sts_ready_i = 1'b1;
    wait_done("len0");
    chk("len0_no_ar", ar_cnt - c0, 0);
    bus.m_axi_arready_i = 1'b0;
    send(64'h8000, 1024, 1'b0, -1);
    cyc(2);
    @(negedge clk);
    chk("issue_arvalid", bus.m_axi_arvalid_o, 1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("mid_rst_valids", {bus.m_axi_arvalid_o, bus.m_axis_tvalid_o, bus.m_sts_valid_o}, 3'b000);
    chk("mid_rst_cmd_ready", bus.s_cmd_ready_o, 0);
    cyc(1);
    rst = 1'b0;
    exp_ar.delete();
    exp_beat.delete();
    exp_sts.delete();
    bus.m_axi_arready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.s_cmd_ready_o, 1);
    cyc(1);
    send(64'h9000, 192, 1'b1, -1);
    wait_done("post_rst_cmd");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
